// File: rtl/ecc_pkg.sv
// Shared definitions for the ECC scalar-multiply controller and the point-add unit.
package ecc_pkg;

  localparam int unsigned WIDTH = 256;

  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    CHK,
    DBL_REQ,
    DBL_WAIT,
    ADD_REQ,
    ADD_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/ecc_scalar_mul_ctrl.sv
// Left-to-right double-and-add sequencer: issues doublings/additions to an
// external point-add unit and accumulates the result R = k*G.
module ecc_scalar_mul_ctrl #(
  parameter int unsigned WIDTH = ecc_pkg::WIDTH,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] Gx,
  input  logic [WIDTH-1:0] Gy,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] Rx,
  output logic [WIDTH-1:0] Ry,
  output logic             err,
  output logic             add_in_valid,
  output logic [WIDTH-1:0] add_Px,
  output logic [WIDTH-1:0] add_Py,
  output logic [WIDTH-1:0] add_Qx,
  output logic [WIDTH-1:0] add_Qy,
  input  logic [WIDTH-1:0] add_Rx,
  input  logic [WIDTH-1:0] add_Ry,
  input  logic             add_out_valid
);
  import ecc_pkg::*;

  state_t           state, state_next;
  logic [WIDTH-1:0] ksh, gx, gy, ax, ay, ax_d, ay_d;
  logic [CNT_W-1:0] cnt;
  logic             load_k, load_g, load_acc, shift, zero_k;
  logic             cnt_last, is_add;

  assign cnt_last     = (cnt == CNT_W'(1));
  assign is_add       = (state == ADD_REQ) || (state == ADD_WAIT);
  assign busy         = (state != IDLE);
  assign add_in_valid = (state == DBL_REQ) || (state == ADD_REQ);
  assign add_Px       = ax;
  assign add_Py       = ay;
  assign add_Qx       = is_add ? gx : ax;
  assign add_Qy       = is_add ? gy : ay;

  assign ax_d = load_g ? gx : (load_acc ? add_Rx : ax);
  assign ay_d = load_g ? gy : (load_acc ? add_Ry : ay);

  // The CHK decision (cnt reaching 0 -> DONE, else DBL_REQ) is taken on the
  // way out of SKIP/WAIT, so it costs no cycle of its own.
  always_comb begin
    state_next = state;
    load_k     = 1'b0;
    load_g     = 1'b0;
    load_acc   = 1'b0;
    shift      = 1'b0;
    zero_k     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load_k     = 1'b1;
          state_next = SKIP;
        end
      end
      SKIP: begin
        shift = 1'b1;
        if (ksh[WIDTH-1]) begin
          load_g     = 1'b1;
          state_next = cnt_last ? DONE : DBL_REQ;
        end else if (cnt_last) begin
          zero_k     = 1'b1;
          state_next = DONE;
        end
      end
      CHK:      state_next = (cnt == '0) ? DONE : DBL_REQ;
      DBL_REQ:  state_next = DBL_WAIT;
      DBL_WAIT: begin
        if (add_out_valid) begin
          load_acc = 1'b1;
          if (ksh[WIDTH-1]) begin
            state_next = ADD_REQ;
          end else begin
            shift      = 1'b1;
            state_next = cnt_last ? DONE : DBL_REQ;
          end
        end
      end
      ADD_REQ:  state_next = ADD_WAIT;
      ADD_WAIT: begin
        if (add_out_valid) begin
          load_acc   = 1'b1;
          shift      = 1'b1;
          state_next = cnt_last ? DONE : DBL_REQ;
        end
      end
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ksh       <= '0;
      gx        <= '0;
      gy        <= '0;
      ax        <= '0;
      ay        <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      Rx        <= '0;
      Ry        <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (load_k) begin
        ksh <= k;
        gx  <= Gx;
        gy  <= Gy;
        cnt <= CNT_W'(WIDTH);
      end else if (shift) begin
        ksh <= {ksh[WIDTH-2:0], 1'b0};
        cnt <= cnt - CNT_W'(1);
      end
      ax        <= ax_d;
      ay        <= ay_d;
      out_valid <= (state_next == DONE);
      if (state_next == DONE) begin
        Rx  <= zero_k ? '0 : ax_d;
        Ry  <= zero_k ? '0 : ay_d;
        err <= zero_k;
      end
    end
  end

endmodule

// File: tb/tb_ecc_scalar_mul_ctrl.sv
// Bench for ecc_scalar_mul_ctrl: integer "points" with G=(1,2), so k*G = (k, 2k).
module tb_ecc_scalar_mul_ctrl;
  localparam int unsigned WIDTH  = 256;
  localparam int unsigned BUDGET = 20000;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct {
    word_t px, py, qx, qy;
  } req_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  in_valid = 1'b0;
  word_t k = '0, Gx = '0, Gy = '0;
  logic  busy, out_valid, err, add_in_valid;
  word_t Rx, Ry, add_Px, add_Py, add_Qx, add_Qy;
  word_t add_Rx = '0, add_Ry = '0;
  logic  add_out_valid = 1'b0;

  ecc_scalar_mul_ctrl #(.WIDTH(WIDTH), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .k(k), .Gx(Gx), .Gy(Gy),
    .busy(busy), .out_valid(out_valid), .Rx(Rx), .Ry(Ry), .err(err),
    .add_in_valid(add_in_valid), .add_Px(add_Px), .add_Py(add_Py),
    .add_Qx(add_Qx), .add_Qy(add_Qy), .add_Rx(add_Rx), .add_Ry(add_Ry),
    .add_out_valid(add_out_valid)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned bitlen(input word_t v);
    for (int i = WIDTH - 1; i >= 0; i--)
      if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic word_t rand_word();
    word_t r;
    for (int j = 0; j < WIDTH / 32; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  // One scalar multiplication with the bench acting as the point-add unit
  // (response dly cycles after the request cycle). inject pulses in_valid
  // while busy; abort resets the DUT early in the first wait.
  task automatic run_op(input word_t kv, input int unsigned dly, input bit inject, input bit abort);
    req_t        exp_q[$];
    req_t        cur, cap;
    word_t       a;
    int unsigned b, n_exp, exp_lat;
    int unsigned n_seen = 0, cycles = 0, cd = 0;
    bit          pend = 0, done = 0, aborted = 0;

    b = bitlen(kv);
    a = word_t'(1);
    for (int i = int'(b) - 2; i >= 0; i--) begin
      cur.px = a; cur.py = a << 1; cur.qx = a; cur.qy = a << 1;
      exp_q.push_back(cur);
      a = a << 1;
      if (kv[i]) begin
        cur.px = a; cur.py = a << 1; cur.qx = word_t'(1); cur.qy = word_t'(2);
        exp_q.push_back(cur);
        a = a + 1;
      end
    end
    n_exp   = exp_q.size();
    exp_lat = (kv == '0) ? WIDTH + 1 : (WIDTH - b + 1) + n_exp * (dly + 2) + 1;

    @(negedge clk);
    add_out_valid = 1'b0;
    in_valid = 1'b1; k = kv; Gx = word_t'(1); Gy = word_t'(2);

    while (!done && cycles < BUDGET && !(aborted && !pend && !add_out_valid)) begin
      @(negedge clk);
      cycles++;
      in_valid = 1'b0; k = rand_word(); Gx = rand_word(); Gy = rand_word();
      add_out_valid = 1'b0;
      if (aborted && !rst_n) rst_n = 1'b1;

      if (aborted) begin
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_req", add_in_valid, 0);
      end else begin
        check("busy", busy, 1);
        if (out_valid) begin
          done = 1;
          check("Rx", Rx, kv);
          check("Ry", Ry, kv << 1);
          check("err", err, word_t'(kv == '0));
          check("req_count", n_seen, n_exp);
          check("latency", cycles, exp_lat);
        end
        if (inject && (cycles == 10 || add_in_valid || out_valid)) begin
          in_valid = 1'b1; k = word_t'(9); Gx = word_t'(1); Gy = word_t'(2);
        end
      end

      if (add_in_valid) begin
        check("one_outstanding", pend, 0);
        n_seen++;
        if (exp_q.size() == 0) begin
          check("extra_req", n_seen, n_exp);
        end else begin
          cur = exp_q.pop_front();
          check("req_Px", add_Px, cur.px);
          check("req_Py", add_Py, cur.py);
          check("req_Qx", add_Qx, cur.qx);
          check("req_Qy", add_Qy, cur.qy);
        end
        cap.px = add_Px; cap.py = add_Py; cap.qx = add_Qx; cap.qy = add_Qy;
        pend = 1; cd = dly;
      end else if (pend) begin
        if (cd == 0) begin
          if (!aborted) begin
            check("hold_Px", add_Px, cap.px);
            check("hold_Qx", add_Qx, cap.qx);
            check("hold_Qy", add_Qy, cap.qy);
          end
          add_Rx = cap.px + cap.qx; add_Ry = cap.py + cap.qy;
          add_out_valid = 1'b1;
          pend = 0;
        end else begin
          cd--;
        end
      end else if (cycles == 2 && !aborted) begin
        add_Rx = rand_word(); add_Ry = rand_word();
        add_out_valid = 1'b1;
      end

      if (abort && !aborted && pend && cd + 3 == dly) begin
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req", add_in_valid, 0);
        check("rst_Rx", Rx, 0);
        check("rst_Ry", Ry, 0);
        check("rst_err", err, 0);
        aborted = 1;
      end
    end

    add_out_valid = 1'b0;
    if (!aborted) begin
      check("completed", done, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("idle_busy", busy, 0);
      check("single_pulse", out_valid, 0);
      check("Rx_held", Rx, kv);
    end else begin
      repeat (3) begin
        @(negedge clk);
        check("post_abort_busy", busy, 0);
        check("post_abort_out", out_valid, 0);
      end
    end
  endtask

  initial begin
    word_t ones, hi1, r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_Rx", Rx, 0);
    check("reset_Ry", Ry, 0);
    check("reset_err", err, 0);
    check("reset_req", add_in_valid, 0);
    check("reset_Px", add_Px, 0);
    check("reset_Qy", add_Qy, 0);
    rst_n = 1'b1;

    run_op(word_t'(1), 3, 0, 0);
    run_op(word_t'(5), 3, 0, 0);
    ones = '1;
    hi1 = '0; hi1[WIDTH-1] = 1'b1; hi1[0] = 1'b1;
    run_op(ones, 0, 0, 0);
    run_op(ones, 7, 0, 0);
    run_op(hi1, 0, 0, 0);
    run_op(hi1, 7, 0, 0);
    run_op(word_t'(0), 3, 0, 0);
    run_op(word_t'(6), 2, 1, 0);
    run_op(word_t'(6), 20, 0, 1);
    run_op(word_t'(3), 2, 0, 0);
    for (int t = 0; t < 4; t++) begin
      r = rand_word();
      run_op(r, $urandom_range(0, 4), 0, 0);
    end
    for (int t = 0; t < 4; t++) begin
      r = word_t'($urandom_range(1, 5000));
      run_op(r, $urandom_range(0, 6), t[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
